// File: rtl/ini_pyld_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// ini_pyld_rr_arbiter_if
//   Bundles the requester-side beat bus, the shared ini payload output toward
//   the split stage, and the length-check status of the payload arbiter.
//
//   master : the arbiter (drives req_ready, axis_out_*, len_err*)
//   slave  : the environment (requesters + split stage)
//
//   req_valid/req_last  NUM_REQ         per-requester beat valid / last
//   req_head            NUM_REQ*HEAD_W  slice i = [i*HEAD_W +: HEAD_W]
//   req_data            NUM_REQ*DATA_W  slice i = [i*DATA_W +: DATA_W]
//   req_ready           NUM_REQ         per-requester ready
//   axis_out_*          -               granted requester's beat to split stage
//   len_err/len_err_id  1 / ID_W        sticky length mismatch + first offender
// ----------------------------------------------------------------------------
interface ini_pyld_rr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int HEAD_W  = 128,
    parameter int DATA_W  = 256,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*HEAD_W-1:0] req_head;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      axis_out_valid;
    logic                      axis_out_last;
    logic [HEAD_W-1:0]         axis_out_head;
    logic [DATA_W-1:0]         axis_out_data;
    logic                      axis_out_ready;

    logic                      len_err;
    logic [ID_W-1:0]           len_err_id;

    modport master (
        input  req_valid, req_last, req_head, req_data, axis_out_ready,
        output req_ready, axis_out_valid, axis_out_last, axis_out_head,
               axis_out_data, len_err, len_err_id
    );

    modport slave (
        output req_valid, req_last, req_head, req_data, axis_out_ready,
        input  req_ready, axis_out_valid, axis_out_last, axis_out_head,
               axis_out_data, len_err, len_err_id
    );
endinterface

// File: rtl/ini_pyld_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ini_pyld_rr_arbiter
//   Packet-granular round-robin arbiter sharing one ini payload path between
//   NUM_REQ DMA payload requesters. A grant is held from the first to the last
//   beat of a packet, so packets never interleave. Each packet's beat count is
//   checked against the byte length in its head; mismatches raise a sticky flag.
//
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : ini_pyld_rr_arbiter_if.master (requester beats in, payload out,
//            length-check status out)
// ----------------------------------------------------------------------------
module ini_pyld_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int HEAD_W  = 128,
    parameter int DATA_W  = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ini_pyld_rr_arbiter_if.master    bus
);
    localparam int BYTES_PB = DATA_W / 8;
    localparam int ID_W     = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e          state_q;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]     beat_cnt_q;
    logic [15:0]     exp_beats_q, exp_beats_d;
    logic            len_err_q;
    logic [ID_W-1:0] len_err_id_q;

    logic            pick_vld;
    logic [15:0]     win_len;
    logic            hs;
    logic            mismatch;
    logic [16:0]     cnt_inc;

    // (a + b) mod NUM_REQ without relying on NUM_REQ being a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return ID_W'(s);
    endfunction

    // Round-robin pick: scanning downward and overwriting leaves the first
    // valid requester at or after rr_ptr as the winner.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a variable unassigned would infer a latch.
        grant_d  = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
                grant_d  = wrap_add(rr_ptr_q, k);
                pick_vld = 1'b1;
            end
        end
    end

    // Expected beats = ceil(len / BYTES_PB); a zero length still moves one beat.
    // Split into quotient + remainder test so the sum cannot overflow 16 bits.
    always_comb begin
        win_len     = bus.req_head[int'(grant_d)*HEAD_W +: 16];
        exp_beats_d = win_len / 16'(BYTES_PB)
                    + {15'd0, (win_len % 16'(BYTES_PB)) != 16'd0};
        if (exp_beats_d == 16'd0) exp_beats_d = 16'd1;
    end

    assign rr_ptr_d = wrap_add(grant_q, 1);

    // Payload path is a straight mux of the granted requester while BUSY.
    always_comb begin
        bus.req_ready      = '0;
        bus.axis_out_valid = 1'b0;
        bus.axis_out_last  = 1'b0;
        bus.axis_out_head  = '0;
        bus.axis_out_data  = '0;
        if (state_q == BUSY) begin
            bus.req_ready[grant_q] = bus.axis_out_ready;
            bus.axis_out_valid     = bus.req_valid[grant_q];
            bus.axis_out_last      = bus.req_last[grant_q];
            bus.axis_out_head      = bus.req_head[int'(grant_q)*HEAD_W +: HEAD_W];
            bus.axis_out_data      = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
        end
    end

    assign hs      = bus.axis_out_valid & bus.axis_out_ready;
    assign cnt_inc = {1'b0, beat_cnt_q} + 17'd1;

    // A packet is wrong if last comes at any count other than the expected one,
    // or if the expected count is reached without last (flagged on that beat).
    assign mismatch = hs & (bus.axis_out_last ? (cnt_inc != {1'b0, exp_beats_q})
                                              : (cnt_inc == {1'b0, exp_beats_q}));

    assign bus.len_err    = len_err_q;
    assign bus.len_err_id = len_err_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            exp_beats_q  <= '0;
            len_err_q    <= 1'b0;
            len_err_id_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q     <= grant_d;
                        exp_beats_q <= exp_beats_d;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mismatch) begin
                        len_err_q <= 1'b1;
                        if (!len_err_q) len_err_id_q <= grant_q;
                    end
                    if (hs) begin
                        if (bus.axis_out_last) begin
                            state_q    <= IDLE;
                            rr_ptr_q   <= rr_ptr_d;
                            beat_cnt_q <= '0;
                        end else if (beat_cnt_q != 16'hFFFF) begin
                            beat_cnt_q <= beat_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ini_pyld_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ini_pyld_rr_arbiter
//   Per-phase packet lists are loaded per requester; a reference model turns
//   them into the expected output beat stream using the round-robin rule, and a
//   monitor pops that stream on every output handshake.
// ----------------------------------------------------------------------------
module tb_ini_pyld_rr_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int HEAD_W   = 128;
    localparam int DATA_W   = 256;
    localparam int BYTES_PB = DATA_W / 8;
    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int TIMEOUT  = 3000;

    typedef struct {
        int                id;
        logic [HEAD_W-1:0] head;
        int                nbeats;
        int                base;
    } pkt_t;

    typedef struct {
        int                id;
        logic [HEAD_W-1:0] head;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ini_pyld_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .HEAD_W(HEAD_W), .DATA_W(DATA_W)) bus ();

    ini_pyld_rr_arbiter #(.NUM_REQ(NUM_REQ), .HEAD_W(HEAD_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic              drv_valid [NUM_REQ];
    logic              drv_last  [NUM_REQ];
    logic [HEAD_W-1:0] drv_head  [NUM_REQ];
    logic [DATA_W-1:0] drv_data  [NUM_REQ];
    logic              out_ready;

    pkt_t              pq [NUM_REQ][$];
    logic [DATA_W-1:0] dstore [$];
    beat_t             exp_q [$];

    bit rand_ready;
    bit gaps_en;
    bit abort;
    int hs_count;
    int n_checks;
    int n_errors;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]                    = drv_valid[i];
            bus.req_last[i]                     = drv_last[i];
            bus.req_head[i*HEAD_W +: HEAD_W]    = drv_head[i];
            bus.req_data[i*DATA_W +: DATA_W]    = drv_data[i];
        end
        bus.axis_out_ready = out_ready;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int beats_for(input int len);
        int e;
        e = (len + BYTES_PB - 1) / BYTES_PB;
        return (e == 0) ? 1 : e;
    endfunction

    task automatic add_pkt(input int id, input int len, input int nbeats);
        pkt_t p;
        p.id         = id;
        p.head       = {$urandom, $urandom, $urandom, $urandom};
        p.head[15:0] = 16'(len);
        p.nbeats     = nbeats;
        p.base       = dstore.size();
        for (int b = 0; b < nbeats; b++) dstore.push_back(rand_data());
        pq[id].push_back(p);
    endtask

    // Reference model: serve whole packets, always choosing the first requester
    // with packets left starting at the pointer, which then moves past the winner.
    task automatic build_expected(input int stop_after, output bit err, output int err_id);
        int idx [NUM_REQ];
        int ptr;
        int cnt;
        int w;
        pkt_t p;
        beat_t e;
        for (int i = 0; i < NUM_REQ; i++) idx[i] = 0;
        ptr = 0; cnt = 0; err = 0; err_id = 0;
        while (1) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (w < 0 && idx[(ptr + k) % NUM_REQ] < pq[(ptr + k) % NUM_REQ].size())
                    w = (ptr + k) % NUM_REQ;
            if (w < 0) break;
            p = pq[w][idx[w]];
            idx[w]++;
            if (!err && p.nbeats != beats_for(int'(p.head[15:0]))) begin
                err = 1; err_id = w;
            end
            for (int b = 0; b < p.nbeats; b++) begin
                if (stop_after <= 0 || cnt < stop_after) begin
                    e.id = w; e.head = p.head; e.data = dstore[p.base + b];
                    e.last = (b == p.nbeats - 1);
                    exp_q.push_back(e);
                end
                cnt++;
            end
            ptr = (w + 1) % NUM_REQ;
        end
    endtask

    // One requester: presents its packets back to back, holding beats until
    // accepted. Valid may drop only once the packet has started (already granted).
    task automatic drive_req(input int i);
        pkt_t p;
        bit hs;
        int waited;
        while (pq[i].size() > 0 && !abort) begin
            p = pq[i].pop_front();
            drv_head[i] = p.head;
            for (int b = 0; b < p.nbeats && !abort; b++) begin
                hs = 0; waited = 0;
                drv_valid[i] = 1'b1;
                drv_last[i]  = (b == p.nbeats - 1);
                drv_data[i]  = dstore[p.base + b];
                while (!hs && !abort) begin
                    @(negedge clk);
                    hs = bus.req_valid[i] && bus.req_ready[i] && rst_n;
                    @(posedge clk); #1;
                    waited++;
                    if (!hs && waited > TIMEOUT) begin
                        n_checks++; n_errors++;
                        $display("FAIL req%0d_timeout: beat %0d not accepted within %0d cycles", i, b, TIMEOUT);
                        abort = 1;
                    end else if (!hs && gaps_en && b > 0) begin
                        drv_valid[i] = ($urandom_range(0, 2) != 0);
                    end
                end
            end
        end
        drv_valid[i] = 1'b0;
        drv_last[i]  = 1'b0;
    endtask

    task automatic run_phase(input string name, input bit rr, input bit gaps, input int abort_at);
        bit eerr;
        int eid;
        int waited;
        build_expected(abort_at, eerr, eid);
        rand_ready = rr; gaps_en = gaps; abort = 0; hs_count = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check({name, "_reset_outputs"},
              {bus.axis_out_valid, bus.axis_out_last, bus.req_ready, bus.len_err, bus.len_err_id}, '0);
        for (int i = 0; i < NUM_REQ; i++) begin
            fork
                automatic int k = i;
                drive_req(k);
            join_none
        end
        if (abort_at > 0) begin
            fork
                begin
                    waited = 0;
                    while (hs_count < abort_at && waited < TIMEOUT) begin
                        @(posedge clk);
                        waited++;
                    end
                    #2;
                    check({name, "_pre_reset_valid"}, bus.axis_out_valid, 1'b1);
                    rst_n = 1'b0;
                    #1;
                    check({name, "_async_reset_outputs"},
                          {bus.axis_out_valid, bus.axis_out_last, bus.req_ready,
                           bus.axis_out_head, bus.axis_out_data, bus.len_err}, '0);
                    abort = 1;
                end
            join_none
        end
        #1;
        rst_n = 1'b1;
        wait fork;
        repeat (3) @(posedge clk);
        #1;
        check({name, "_all_beats_seen"}, exp_q.size(), 0);
        if (abort_at <= 0)
            check({name, "_len_err"}, {bus.len_err, bus.len_err_id}, {eerr, ID_W'(eid)});
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        dstore.delete();
    endtask

    // Split-stage model: always ready, or a fair coin per cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every output handshake must be the next expected beat.
    initial begin
        bit prev_last;
        beat_t e;
        logic [NUM_REQ-1:0] oh;
        prev_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_last = 0;
            end else begin
                if (prev_last) check("bubble_after_last", bus.axis_out_valid, 1'b0);
                prev_last = 0;
                if (bus.axis_out_valid && bus.axis_out_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_beat: data %0h with no beat expected", bus.axis_out_data);
                    end else begin
                        e = exp_q.pop_front();
                        oh = '0;
                        oh[e.id] = 1'b1;
                        check("beat_data", bus.axis_out_data, e.data);
                        check("beat_head", bus.axis_out_head, e.head);
                        check("beat_last", bus.axis_out_last, e.last);
                        check("req_ready_grant", bus.req_ready, oh);
                        prev_last = bus.axis_out_last;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int nb;
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_valid[i] = 1'b0; drv_last[i] = 1'b0; drv_head[i] = '0; drv_data[i] = '0;
        end
        n_checks = 0; n_errors = 0;
        repeat (2) @(posedge clk);

        // Single packet, 64 bytes -> 2 beats.
        add_pkt(0, 64, 2);
        run_phase("single", 0, 0, 0);

        // Two requesters, three packets each -> strict 0,1,0,1,0,1.
        for (int p = 0; p < 3; p++) begin
            len = $urandom_range(1, 4 * BYTES_PB);
            add_pkt(0, len, beats_for(len));
            len = $urandom_range(1, 4 * BYTES_PB);
            add_pkt(1, len, beats_for(len));
        end
        run_phase("alternate", 0, 0, 0);

        // 4-beat packet with random output backpressure and valid gaps.
        add_pkt(0, 4 * BYTES_PB, 4);
        run_phase("backpressure", 1, 1, 0);

        // Zero length (1 beat, fine), short packet from req2, long one from req3.
        add_pkt(1, 0, 1);
        add_pkt(2, 96, 2);
        add_pkt(3, 32, 3);
        run_phase("len_check", 0, 0, 0);

        // Reset during beat 2 of req1's 4-beat packet, then fresh arbitration from 0.
        add_pkt(0, 64, 2);
        add_pkt(1, 128, 4);
        run_phase("mid_reset", 0, 0, 3);
        add_pkt(1, 32, 1);
        add_pkt(0, 32, 1);
        run_phase("after_reset", 0, 0, 0);

        // Only the highest requester: back-to-back packets with a bubble each.
        add_pkt(3, 64, 2);
        add_pkt(3, 96, 3);
        run_phase("req3_only", 0, 0, 0);

        // Mixed random traffic over all requesters, occasional bad lengths.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
                    len = $urandom_range(0, 5 * BYTES_PB);
                    nb  = beats_for(len);
                    if ($urandom_range(0, 5) == 0) nb = ($urandom_range(0, 1) == 0 && nb > 1) ? nb - 1 : nb + 1;
                    add_pkt(i, len, nb);
                end
            end
            run_phase("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
